// File: rtl/move_ctrl_if.sv
// Button/playfield side bundle of move_ctrl: raw buttons and playfield levels in,
// move strobes and piece code out.
interface move_ctrl_if;
  logic       btnLeft;
  logic       btnRight;
  logic       btnDown;
  logic       btnRotate;
  logic       nextBlockTrue;
  logic       gameOver;
  logic       leftTrue;
  logic       rightTrue;
  logic       downTrue;
  logic       rotateTrue;
  logic [2:0] blockType;

  modport master (
    output btnLeft, btnRight, btnDown, btnRotate, nextBlockTrue, gameOver,
    input  leftTrue, rightTrue, downTrue, rotateTrue, blockType
  );

  modport slave (
    input  btnLeft, btnRight, btnDown, btnRotate, nextBlockTrue, gameOver,
    output leftTrue, rightTrue, downTrue, rotateTrue, blockType
  );
endinterface

// File: rtl/move_ctrl.sv
// Button debounce, auto-repeat, gravity and priority arbitration into one-hot move
// strobes, plus LFSR-based piece selection for the playfield.
module move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int GRAVITY_CYCLES  = 25000000
) (
  input logic       clock,
  input logic       resetn,
  move_ctrl_if.slave bus
);

  localparam logic [24:0] DEB_LAST  = 25'(DEBOUNCE_CYCLES - 1);
  localparam logic [24:0] DELAY_CNT = 25'(REPEAT_DELAY);
  localparam logic [24:0] RATE_CNT  = 25'(REPEAT_RATE);
  localparam logic [24:0] GRAV_LAST = 25'(GRAVITY_CYCLES - 1);

  // Bit order is ascending priority: 0 down, 1 right, 2 left, 3 rotate.
  logic [3:0]  btn_raw;
  logic [3:0]  stable;
  logic [3:0]  press;
  logic [2:0]  repeat_hit;
  logic [3:0]  req_set;
  logic [3:0]  grant;
  logic        grav_hit;
  logic [3:0]  pending_reg;
  logic [3:0]  strobe_reg;
  logic [24:0] grav_reg;
  logic [15:0] lfsr_reg;
  logic [2:0]  block_reg;

  assign btn_raw = {bus.btnRotate, bus.btnLeft, bus.btnRight, bus.btnDown};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic        s1_reg;
      logic        s2_reg;
      logic        stable_bit_reg;
      logic        prev_bit_reg;
      logic [24:0] deb_reg;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          s1_reg         <= 1'b0;
          s2_reg         <= 1'b0;
          stable_bit_reg <= 1'b0;
          prev_bit_reg   <= 1'b0;
          deb_reg        <= '0;
        end else begin
          s1_reg       <= btn_raw[gi];
          s2_reg       <= s1_reg;
          prev_bit_reg <= stable_bit_reg;
          if (s2_reg == stable_bit_reg) begin
            deb_reg <= '0;
          end else if (deb_reg == DEB_LAST) begin
            stable_bit_reg <= s2_reg;
            deb_reg        <= '0;
          end else begin
            deb_reg <= deb_reg + 25'd1;
          end
        end
      end

      assign stable[gi] = stable_bit_reg;
      assign press[gi]  = stable_bit_reg & ~prev_bit_reg;
    end

    // Rotate has no hold counter; it never repeats.
    for (gi = 0; gi < 3; gi++) begin : g_rep
      logic [24:0] hold_reg;
      logic        rep_reg;

      assign repeat_hit[gi] = stable[gi] && !press[gi] && !bus.gameOver &&
                              (hold_reg == (rep_reg ? RATE_CNT : DELAY_CNT));

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          hold_reg <= '0;
          rep_reg  <= 1'b0;
        end else if (!stable[gi] || bus.gameOver) begin
          hold_reg <= '0;
          rep_reg  <= 1'b0;
        end else if (press[gi]) begin
          hold_reg <= 25'd1;
          rep_reg  <= 1'b0;
        end else if (repeat_hit[gi]) begin
          hold_reg <= 25'd1;
          rep_reg  <= 1'b1;
        end else begin
          hold_reg <= hold_reg + 25'd1;
        end
      end
    end
  endgenerate

  always_comb begin
    grant = 4'b0000;
    if (pending_reg[3])      grant = 4'b1000;
    else if (pending_reg[2]) grant = 4'b0100;
    else if (pending_reg[1]) grant = 4'b0010;
    else if (pending_reg[0]) grant = 4'b0001;
  end

  // A down strobe being issued restarts the period, so a coincident wrap is dropped.
  assign grav_hit = (grav_reg == GRAV_LAST) && !bus.gameOver &&
                    !bus.nextBlockTrue && !grant[0];
  assign req_set  = press | {1'b0, repeat_hit} | {3'b000, grav_hit};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending_reg <= '0;
      strobe_reg  <= '0;
      grav_reg    <= '0;
    end else if (bus.gameOver) begin
      pending_reg <= '0;
      strobe_reg  <= '0;
      grav_reg    <= '0;
    end else begin
      pending_reg <= (pending_reg & ~grant) | req_set;
      strobe_reg  <= grant;
      // The strobe cycle itself is count 0 of the new period, hence the load of 1.
      if (bus.nextBlockTrue)  grav_reg <= '0;
      else if (grant[0])      grav_reg <= 25'd1;
      else if (grav_hit)      grav_reg <= '0;
      else                    grav_reg <= grav_reg + 25'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lfsr_reg  <= 16'hACE1;
      block_reg <= 3'd0;
    end else begin
      lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
      if (bus.nextBlockTrue) begin
        if (lfsr_reg[2:0] != 3'd7)      block_reg <= lfsr_reg[2:0];
        else if (lfsr_reg[5:3] != 3'd7) block_reg <= lfsr_reg[5:3];
        else                            block_reg <= 3'd0;
      end
    end
  end

  assign bus.rotateTrue = strobe_reg[3];
  assign bus.leftTrue   = strobe_reg[2];
  assign bus.rightTrue  = strobe_reg[1];
  assign bus.downTrue   = strobe_reg[0];
  assign bus.blockType  = block_reg;

endmodule

// File: tb/tb_move_ctrl.sv
// Scoreboard bench for move_ctrl: directed button/playfield stimulus pushes expected
// strobes (relative edge, code) into a queue that a forked monitor pops and checks.
module tb_move_ctrl;
  logic clock  = 1'b0;
  logic resetn = 1'b1;

  move_ctrl_if bus();

  move_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8),
    .GRAVITY_CYCLES (50)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   base     = 0;
  logic [15:0] lfsr_m;

  localparam logic [3:0] ROT = 4'b1000, LFT = 4'b0100, RGT = 4'b0010, DWN = 4'b0001;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference LFSR: right-shift Fibonacci, taps 16,14,13,11, seed ACE1.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) lfsr_m <= 16'hACE1;
    else         lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  function automatic logic [2:0] pick(logic [15:0] l);
    if (l[2:0] != 3'd7) return l[2:0];
    if (l[5:3] != 3'd7) return l[5:3];
    return 3'd0;
  endfunction

  function automatic logic [3:0] strobes();
    return {bus.rotateTrue, bus.leftTrue, bus.rightTrue, bus.downTrue};
  endfunction

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic set_btn(logic [3:0] b);
    bus.btnRotate = b[3];
    bus.btnLeft   = b[2];
    bus.btnRight  = b[1];
    bus.btnDown   = b[0];
  endtask

  // Edge 0 is the first rising edge after release; a strobe at edge e is seen at the
  // following falling edge, where cyc == base + e + 1.
  task automatic expect_at(int rel, logic [3:0] code);
    exp_t e;
    e.cyc  = base + rel + 1;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic wait_rel(int r);
    while (cyc < base + r) @(negedge clock);
  endtask

  task automatic do_reset(logic [3:0] btn_during, logic [3:0] btn_after);
    @(negedge clock);
    resetn = 1'b0;
    bus.nextBlockTrue = 1'b0;
    bus.gameOver      = 1'b0;
    set_btn(btn_during);
    #1;
    check("reset_strobes_now", int'(strobes()), 0);
    check("reset_block_now", int'(bus.blockType), 0);
    repeat (3) @(negedge clock);
    check("reset_strobes_held", int'(strobes()), 0);
    check("reset_block_held", int'(bus.blockType), 0);
    set_btn(btn_after);
    resetn = 1'b1;
    base   = cyc;
  endtask

  task automatic end_test(string name);
    #2;
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pulse_piece(string name);
    logic [2:0] exp_bt;
    bus.nextBlockTrue = 1'b1;
    exp_bt = pick(lfsr_m);
    @(negedge clock);
    bus.nextBlockTrue = 1'b0;
    check(name, int'(bus.blockType), int'(exp_bt));
  endtask

  task automatic monitor();
    exp_t e;
    logic [3:0] s;
    forever begin
      @(negedge clock);
      s = strobes();
      if (s != 4'b0000) begin
        check("strobe_onehot", $countones(s), 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got code %b at edge %0d, expected no strobe",
                   s, cyc - base - 1);
        end else begin
          e = exp_q.pop_front();
          check("strobe_code", int'(s), int'(e.code));
          check("strobe_edge", cyc - base - 1, e.cyc - base - 1);
        end
      end
    end
  endtask

  initial begin
    logic [6:0] seen;
    logic [2:0] exp_bt;
    set_btn(4'b0000);
    bus.nextBlockTrue = 1'b0;
    bus.gameOver      = 1'b0;

    // Reset with every button high; only left stays high after release.
    do_reset(4'b1111, LFT);
    fork monitor(); join_none
    expect_at(7, LFT);
    wait_rel(8);  set_btn(4'b0000);
    wait_rel(45); end_test("t1_reset_press_queue");

    // Right bounces every 2 cycles, then a clean high from edge 20.
    do_reset(4'b0000, 4'b0000);
    for (int i = 0; i < 20; i += 2) begin
      wait_rel(i);
      bus.btnRight = ((i / 2) % 2 == 0);
    end
    wait_rel(20); bus.btnRight = 1'b1;
    expect_at(27, RGT);
    wait_rel(30); bus.btnRight = 1'b0;
    wait_rel(45); end_test("t2_bounce_queue");

    // Left held 60 cycles: press at 7, repeats every 20 then 8 until release
    // debounces at edge 65; gravity fires at 50 in between.
    do_reset(4'b0000, LFT);
    expect_at(7, LFT);  expect_at(27, LFT); expect_at(35, LFT); expect_at(43, LFT);
    expect_at(50, DWN); expect_at(51, LFT); expect_at(59, LFT);
    wait_rel(60); set_btn(4'b0000);
    wait_rel(95); end_test("t3_repeat_queue");

    // Gravity every 50; a button down at 127 restarts the period.
    do_reset(4'b0000, 4'b0000);
    expect_at(50, DWN); expect_at(100, DWN);
    wait_rel(120); bus.btnDown = 1'b1;
    expect_at(127, DWN);
    wait_rel(128); bus.btnDown = 1'b0;
    expect_at(177, DWN);
    wait_rel(190); end_test("t4_gravity_queue");

    // Rotate and left become stable together.
    do_reset(4'b0000, ROT | LFT);
    expect_at(7, ROT); expect_at(8, LFT);
    wait_rel(9);  set_btn(4'b0000);
    wait_rel(45); end_test("t5_arbitration_queue");

    // 1000 pieces: exact value, range, hold, and full coverage of 0..6.
    do_reset(4'b0000, 4'b0000);
    seen = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      bus.nextBlockTrue = 1'b1;
      exp_bt = pick(lfsr_m);
      @(negedge clock);
      bus.nextBlockTrue = 1'b0;
      check("piece_value", int'(bus.blockType), int'(exp_bt));
      check("piece_range", int'(bus.blockType != 3'd7), 1);
      if (bus.blockType != 3'd7) seen[bus.blockType] = 1'b1;
      @(negedge clock);
      check("piece_hold", int'(bus.blockType), int'(exp_bt));
    end
    for (int v = 0; v < 7; v++) check("piece_seen", int'(seen[v]), 1);
    end_test("t6_pieces_queue");

    // gameOver with left held: no strobes, pieces still update, gravity restarts
    // from 0 when gameOver drops before edge 100.
    do_reset(4'b0000, LFT);
    bus.gameOver = 1'b1;
    wait_rel(10); pulse_piece("gameover_piece");
    wait_rel(30); pulse_piece("gameover_piece");
    wait_rel(60); pulse_piece("gameover_piece");
    wait_rel(70); set_btn(4'b0000);
    wait_rel(100); bus.gameOver = 1'b0;
    expect_at(150, DWN);
    wait_rel(160); end_test("t7_gameover_queue");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
